// File: rtl/adder_tree_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed adder-tree scheduler.
package adder_tree_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int unsigned num_operands(input int unsigned levels);
    return 32'd1 << levels;
  endfunction

  function automatic int unsigned num_steps(input int unsigned levels);
    return num_operands(levels) - 32'd1;
  endfunction

  // Level l (1-based) halves the live slot count, so it needs N>>l additions.
  function automatic int unsigned steps_in_level(input int unsigned levels, input int unsigned l);
    return num_operands(levels) >> l;
  endfunction

endpackage

// File: rtl/adder_tree_branch.sv
// Two-input adder node of the adder-tree family; result is one bit wider than the operands.
module adder_tree_branch #(
  parameter int ADDER_WIDTH = 9,
  parameter int EXTRA_BITS  = 0
) (
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] a,
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] b,
  output logic [ADDER_WIDTH+EXTRA_BITS:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_tree_sched.sv
// Reduces 2**LEVELS operands to one sum with a single shared adder, one pairwise add per cycle,
// in the same level-by-level order as the spatial tree.
module adder_tree_sched
  import adder_tree_sched_pkg::*;
#(
  parameter int ADDER_WIDTH = 9,
  parameter int LEVELS      = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [(2**LEVELS)*ADDER_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ADDER_WIDTH+LEVELS-1:0]      out_sum,
  output logic                               busy
);

  localparam int unsigned N          = num_operands(LEVELS);
  localparam int unsigned SW         = ADDER_WIDTH + LEVELS;
  localparam int unsigned SCW        = $clog2(N);
  localparam int unsigned LW         = $clog2(LEVELS + 1);
  localparam int unsigned LAST_LEVEL = LEVELS - 1;

  state_e           state_q, state_d;
  logic [SCW-1:0]   step_q, step_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SW-1:0]    slot_q [N];
  logic [SW-1:0]    slot_d [N];
  logic [SW-1:0]    sum_q, sum_d;
  logic             busy_q;

  logic [SW-2:0]    add_a, add_b;
  logic [SW-1:0]    add_sum;
  logic             last_in_level, last_level;
  logic             slot_msb_unused;

  // Step i of any level reads slots 2i and 2i+1; the slot MSB can never be set before the final add.
  always_comb begin
    add_a           = '0;
    add_b           = '0;
    slot_msb_unused = 1'b0;
    for (int unsigned k = 0; k < N / 2; k++) begin
      if (32'(step_q) == k) begin
        add_a = slot_q[2*k][SW-2:0];
        add_b = slot_q[2*k+1][SW-2:0];
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      slot_msb_unused = slot_msb_unused ^ slot_q[k][SW-1];
    end
  end

  adder_tree_branch #(
    .ADDER_WIDTH (ADDER_WIDTH),
    .EXTRA_BITS  (LEVELS - 1)
  ) u_branch (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign last_in_level = (32'(step_q) == steps_in_level(LEVELS, 32'(level_q) + 32'd1) - 32'd1);
  assign last_level    = (32'(level_q) == LAST_LEVEL);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    level_d = level_q;
    slot_d  = slot_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < N; k++) begin
            slot_d[k] = SW'(in_data[k*ADDER_WIDTH +: ADDER_WIDTH]);
          end
          step_d  = '0;
          level_d = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        for (int unsigned k = 0; k < N / 2; k++) begin
          if (32'(step_q) == k) slot_d[k] = add_sum;
        end
        if (last_in_level) begin
          step_d = '0;
          if (last_level) begin
            sum_d   = add_sum;
            state_d = DONE;
          end else begin
            level_d = level_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      level_q <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      level_q <= level_d;
      sum_q   <= sum_d;
      busy_q  <= (state_d == REDUCE);
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign busy      = busy_q;

endmodule
